// File: rtl/fifo_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ptr_ctrl
// Description : Write-side pointer controller for an asynchronous FIFO.
//               Accepts write requests, drives the memory write strobe and
//               address, and keeps the binary write pointer that feeds the
//               downstream binary-to-Gray converter. It also decodes the
//               synchronized Gray read pointer and derives FULL, ALMOST_FULL,
//               the fill level and a sticky OVERFLOW flag.
// Ports       :
//   CLK              in   write-domain clock, rising edge
//   RST              in   asynchronous active-low reset
//   W_INC            in   write request, one entry per cycle
//   RD_PTR_GRAY_SYNC in   Gray read pointer, already synchronized to CLK
//   CLR_OVF          in   clears OVERFLOW (a same-cycle set wins)
//   W_EN             out  memory write strobe (W_INC & ~FULL)
//   W_ADDR           out  memory write address (low bits of W_PTR_BIN)
//   W_PTR_BIN        out  registered binary write pointer
//   FULL             out  registered full flag
//   ALMOST_FULL      out  registered, level >= AF_TH
//   W_LEVEL          out  registered fill level, 0..DEPTH
//   OVERFLOW         out  sticky, write attempted while FULL
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_SIZE = 3,
    parameter int AF_TH     = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   W_INC,
    input  logic [ADDR_SIZE:0]     RD_PTR_GRAY_SYNC,
    input  logic                   CLR_OVF,
    output logic                   W_EN,
    output logic [ADDR_SIZE-1:0]   W_ADDR,
    output logic [ADDR_SIZE:0]     W_PTR_BIN,
    output logic                   FULL,
    output logic                   ALMOST_FULL,
    output logic [ADDR_SIZE:0]     W_LEVEL,
    output logic                   OVERFLOW
);

    localparam int                  PTR_SIZE = ADDR_SIZE + 1;
    localparam logic [PTR_SIZE-1:0] C_DEPTH  = PTR_SIZE'(1) << ADDR_SIZE;
    localparam logic [PTR_SIZE-1:0] C_AF_TH  = PTR_SIZE'(AF_TH);

    logic [PTR_SIZE-1:0] w_rd_ptr_bin;
    logic                w_en;

    logic [PTR_SIZE-1:0] wptr_q,  wptr_d;
    logic [PTR_SIZE-1:0] level_q, level_d;
    logic                full_q,  full_d;
    logic                afull_q, afull_d;
    logic                ovf_q,   ovf_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
    // above its position. Written per bit so there is no chained
    // self-dependency inside one vector; any pointer jump decodes correctly.
    for (genvar gi = 0; gi < PTR_SIZE; gi++) begin : g_gray_dec
        assign w_rd_ptr_bin[gi] = ^(RD_PTR_GRAY_SYNC >> gi);
    end

    assign w_en = W_INC & ~full_q;

    always_comb begin
        wptr_d  = w_en ? (wptr_q + PTR_SIZE'(1)) : wptr_q;
        // Modular difference of the extended pointers gives 0..DEPTH; the
        // extra MSB distinguishes full from empty.
        level_d = wptr_d - w_rd_ptr_bin;
        full_d  = (level_d == C_DEPTH);
        afull_d = (level_d >= C_AF_TH);
        // Set has priority over clear so a dropped write is never lost.
        if (W_INC && full_q) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign W_EN        = w_en;
    assign W_ADDR      = wptr_q[ADDR_SIZE-1:0];
    assign W_PTR_BIN   = wptr_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign W_LEVEL     = level_q;
    assign OVERFLOW    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ptr_ctrl
// Description : Directed self-checking bench for fifo_wr_ptr_ctrl
//               (ADDR_SIZE=3, AF_TH=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ptr_ctrl;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [3:0] RD_PTR_GRAY_SYNC;
    logic       CLR_OVF;
    logic       W_EN;
    logic [2:0] W_ADDR;
    logic [3:0] W_PTR_BIN;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] W_LEVEL;
    logic       OVERFLOW;

    int errors = 0;
    int checks = 0;

    fifo_wr_ptr_ctrl #(
        .ADDR_SIZE (3),
        .AF_TH     (6)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .W_INC            (W_INC),
        .RD_PTR_GRAY_SYNC (RD_PTR_GRAY_SYNC),
        .CLR_OVF          (CLR_OVF),
        .W_EN             (W_EN),
        .W_ADDR           (W_ADDR),
        .W_PTR_BIN        (W_PTR_BIN),
        .FULL             (FULL),
        .ALMOST_FULL      (ALMOST_FULL),
        .W_LEVEL          (W_LEVEL),
        .OVERFLOW         (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST              = 1'b0;
        W_INC            = 1'b0;
        CLR_OVF          = 1'b0;
        RD_PTR_GRAY_SYNC = 4'b0000;
        #2;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST              = 1'b0;
        W_INC            = 1'b1;
        CLR_OVF          = 1'b0;
        RD_PTR_GRAY_SYNC = 4'b0000;
        step();
        step();
        checks++; if (W_PTR_BIN !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", W_PTR_BIN); end
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", FULL); end
        checks++; if (W_LEVEL !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", W_LEVEL); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", OVERFLOW); end
        checks++; if (ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL reset_af: got %0b want 0", ALMOST_FULL); end
        checks++; if (W_EN !== 1'b1) begin errors++; $display("FAIL reset_wen: got %0b want 1", W_EN); end
        W_INC = 1'b0;
        RST   = 1'b1;
        step();
        W_INC = 1'b1;
        step();
        W_INC = 1'b0;
        checks++; if (W_PTR_BIN !== 4'd1) begin errors++; $display("FAIL first_write_ptr: got %0d want 1", W_PTR_BIN); end
        checks++; if (W_LEVEL !== 4'd1) begin errors++; $display("FAIL first_write_level: got %0d want 1", W_LEVEL); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            W_INC = 1'b1;
            #1;
            checks++; if (W_ADDR !== 3'(i)) begin errors++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, W_ADDR, i); end
            checks++; if (W_EN !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %0b want 1", i, W_EN); end
            step();
            checks++; if (W_LEVEL !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, W_LEVEL, i + 1); end
            checks++; if (ALMOST_FULL !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d]: got %0b want %0b", i, ALMOST_FULL, (i + 1 >= 6)); end
            checks++; if (FULL !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, FULL, (i == 7)); end
        end
        W_INC = 1'b0;
        checks++; if (W_PTR_BIN !== 4'd8) begin errors++; $display("FAIL fill_ptr: got %0d want 8", W_PTR_BIN); end
    endtask

    task automatic test_overflow();
        W_INC = 1'b1;
        #1;
        checks++; if (W_EN !== 1'b0) begin errors++; $display("FAIL ovf_wen: got %0b want 0", W_EN); end
        step();
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", OVERFLOW); end
        checks++; if (W_PTR_BIN !== 4'd8) begin errors++; $display("FAIL ovf_ptr1: got %0d want 8", W_PTR_BIN); end
        step();
        checks++; if (W_PTR_BIN !== 4'd8) begin errors++; $display("FAIL ovf_ptr2: got %0d want 8", W_PTR_BIN); end
        W_INC = 1'b0;
        step();
        step();
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", OVERFLOW); end
        W_INC   = 1'b1;
        CLR_OVF = 1'b1;
        step();
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b want 1", OVERFLOW); end
        W_INC = 1'b0;
        step();
        CLR_OVF = 1'b0;
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", OVERFLOW); end
        checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %0b want 1", FULL); end
    endtask

    task automatic test_drain();
        RD_PTR_GRAY_SYNC = 4'b0001;   // bin 1
        step();
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL drain_full: got %0b want 0", FULL); end
        checks++; if (W_LEVEL !== 4'd7) begin errors++; $display("FAIL drain_level7: got %0d want 7", W_LEVEL); end
        checks++; if (ALMOST_FULL !== 1'b1) begin errors++; $display("FAIL drain_af7: got %0b want 1", ALMOST_FULL); end
        RD_PTR_GRAY_SYNC = 4'b1100;   // bin 8
        step();
        checks++; if (W_LEVEL !== 4'd0) begin errors++; $display("FAIL drain_level0: got %0d want 0", W_LEVEL); end
        checks++; if (ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL drain_af0: got %0b want 0", ALMOST_FULL); end
    endtask

    task automatic test_wrap();
        // Pointer is 8 with read pointer 8; advance write pointer to 15.
        for (int i = 0; i < 7; i++) begin
            W_INC = 1'b1;
            step();
        end
        W_INC            = 1'b0;
        RD_PTR_GRAY_SYNC = 4'b1000;   // bin 15
        step();
        checks++; if (W_PTR_BIN !== 4'd15) begin errors++; $display("FAIL wrap_ptr15: got %0d want 15", W_PTR_BIN); end
        checks++; if (W_LEVEL !== 4'd0) begin errors++; $display("FAIL wrap_level0: got %0d want 0", W_LEVEL); end
        W_INC = 1'b1;
        step();
        checks++; if (W_PTR_BIN !== 4'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d want 0", W_PTR_BIN); end
        checks++; if (W_LEVEL !== 4'd1) begin errors++; $display("FAIL wrap_level1: got %0d want 1", W_LEVEL); end
        for (int i = 2; i <= 8; i++) begin
            step();
            checks++; if (W_LEVEL !== 4'(i)) begin errors++; $display("FAIL wrap_level[%0d]: got %0d want %0d", i, W_LEVEL, i); end
            checks++; if (FULL !== (i == 8)) begin errors++; $display("FAIL wrap_full[%0d]: got %0b want %0b", i, FULL, (i == 8)); end
        end
        W_INC = 1'b0;
        checks++; if (W_PTR_BIN !== 4'd7) begin errors++; $display("FAIL wrap_ptr7: got %0d want 7", W_PTR_BIN); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            W_INC = 1'b1;
            step();
        end
        checks++; if (W_LEVEL !== 4'd5) begin errors++; $display("FAIL b2b_level_pre: got %0d want 5", W_LEVEL); end
        RD_PTR_GRAY_SYNC = 4'b0001;   // read advances to 1 while writing
        step();
        W_INC = 1'b0;
        checks++; if (W_LEVEL !== 4'd5) begin errors++; $display("FAIL b2b_level: got %0d want 5", W_LEVEL); end
        checks++; if (W_PTR_BIN !== 4'd6) begin errors++; $display("FAIL b2b_ptr: got %0d want 6", W_PTR_BIN); end
    endtask

    task automatic test_mid_reset();
        RST = 1'b0;
        #1;
        checks++; if (W_PTR_BIN !== 4'd0) begin errors++; $display("FAIL midrst_ptr: got %0d want 0", W_PTR_BIN); end
        checks++; if (W_LEVEL !== 4'd0) begin errors++; $display("FAIL midrst_level: got %0d want 0", W_LEVEL); end
        checks++; if (W_ADDR !== 3'd0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", W_ADDR); end
        checks++; if ({FULL, ALMOST_FULL, OVERFLOW} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b want 000", {FULL, ALMOST_FULL, OVERFLOW}); end
        RD_PTR_GRAY_SYNC = 4'b0000;
        step();
        RST = 1'b1;
        step();
        checks++; if (W_PTR_BIN !== 4'd0) begin errors++; $display("FAIL midrst_release_ptr: got %0d want 0", W_PTR_BIN); end
        checks++; if (W_LEVEL !== 4'd0) begin errors++; $display("FAIL midrst_release_level: got %0d want 0", W_LEVEL); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
